// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the arbiter FSM state encodings.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_XFER = 2'd1,
    W_RESP = 2'd2
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rstate_t;

endpackage

// File: rtl/axil_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port that did not win last.
module axil_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       any
);

  assign any = |req;
  assign gnt = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/axi4_lite_arbiter_2to1.sv
// Two-master to one-slave AXI4-Lite arbiter; write and read paths arbitrate independently,
// one outstanding transaction each, granted channels passed through combinationally.
module axi4_lite_arbiter_2to1
  import axi4_lite_pkg::*;
#(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  // upstream port 0
  input  logic [ADDRESS-1:0]      S0_AWADDR,
  input  logic                    S0_AWVALID,
  output logic                    S0_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S0_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S0_WSTRB,
  input  logic                    S0_WVALID,
  output logic                    S0_WREADY,
  output logic [1:0]              S0_BRESP,
  output logic                    S0_BVALID,
  input  logic                    S0_BREADY,
  input  logic [ADDRESS-1:0]      S0_ARADDR,
  input  logic                    S0_ARVALID,
  output logic                    S0_ARREADY,
  output logic [DATA_WIDTH-1:0]   S0_RDATA,
  output logic [1:0]              S0_RRESP,
  output logic                    S0_RVALID,
  input  logic                    S0_RREADY,
  // upstream port 1
  input  logic [ADDRESS-1:0]      S1_AWADDR,
  input  logic                    S1_AWVALID,
  output logic                    S1_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S1_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S1_WSTRB,
  input  logic                    S1_WVALID,
  output logic                    S1_WREADY,
  output logic [1:0]              S1_BRESP,
  output logic                    S1_BVALID,
  input  logic                    S1_BREADY,
  input  logic [ADDRESS-1:0]      S1_ARADDR,
  input  logic                    S1_ARVALID,
  output logic                    S1_ARREADY,
  output logic [DATA_WIDTH-1:0]   S1_RDATA,
  output logic [1:0]              S1_RRESP,
  output logic                    S1_RVALID,
  input  logic                    S1_RREADY,
  // downstream port
  output logic [ADDRESS-1:0]      M_AWADDR,
  output logic                    M_AWVALID,
  input  logic                    M_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_WSTRB,
  output logic                    M_WVALID,
  input  logic                    M_WREADY,
  input  logic [1:0]              M_BRESP,
  input  logic                    M_BVALID,
  output logic                    M_BREADY,
  output logic [ADDRESS-1:0]      M_ARADDR,
  output logic                    M_ARVALID,
  input  logic                    M_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_RDATA,
  input  logic [1:0]              M_RRESP,
  input  logic                    M_RVALID,
  output logic                    M_RREADY
);

  localparam int STRB = DATA_WIDTH/8;

  // upstream ports gathered into index-able arrays (index 1 = S1)
  logic [1:0][ADDRESS-1:0]    s_awaddr, s_araddr;
  logic [1:0][DATA_WIDTH-1:0] s_wdata, s_rdata;
  logic [1:0][STRB-1:0]       s_wstrb;
  logic [1:0][1:0]            s_bresp, s_rresp;
  logic [1:0] s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic [1:0] s_awready, s_wready, s_bvalid, s_arready, s_rvalid;

  assign s_awaddr  = {S1_AWADDR,  S0_AWADDR};
  assign s_araddr  = {S1_ARADDR,  S0_ARADDR};
  assign s_wdata   = {S1_WDATA,   S0_WDATA};
  assign s_wstrb   = {S1_WSTRB,   S0_WSTRB};
  assign s_awvalid = {S1_AWVALID, S0_AWVALID};
  assign s_wvalid  = {S1_WVALID,  S0_WVALID};
  assign s_bready  = {S1_BREADY,  S0_BREADY};
  assign s_arvalid = {S1_ARVALID, S0_ARVALID};
  assign s_rready  = {S1_RREADY,  S0_RREADY};

  assign {S1_AWREADY, S0_AWREADY} = s_awready;
  assign {S1_WREADY,  S0_WREADY}  = s_wready;
  assign {S1_BVALID,  S0_BVALID}  = s_bvalid;
  assign {S1_ARREADY, S0_ARREADY} = s_arready;
  assign {S1_RVALID,  S0_RVALID}  = s_rvalid;
  assign S0_BRESP = s_bresp[0];
  assign S1_BRESP = s_bresp[1];
  assign S0_RRESP = s_rresp[0];
  assign S1_RRESP = s_rresp[1];
  assign S0_RDATA = s_rdata[0];
  assign S1_RDATA = s_rdata[1];

  // ---------------- write path ----------------
  wstate_t wstate, wstate_nxt;
  logic    wgnt, wlast, w_pick, w_any;
  logic    aw_done, w_done, aw_hs, w_hs, b_hs;

  axil_rr_arb2 u_warb (
    .req  (s_awvalid | s_wvalid),
    .last (wlast),
    .gnt  (w_pick),
    .any  (w_any)
  );

  always_comb begin
    wstate_nxt = wstate;
    M_AWADDR   = '0;
    M_AWVALID  = 1'b0;
    M_WDATA    = '0;
    M_WSTRB    = '0;
    M_WVALID   = 1'b0;
    M_BREADY   = 1'b0;
    s_awready  = '0;
    s_wready   = '0;
    s_bvalid   = '0;
    s_bresp    = '0;
    aw_hs      = 1'b0;
    w_hs       = 1'b0;
    b_hs       = 1'b0;
    case (wstate)
      W_IDLE: if (w_any) wstate_nxt = W_XFER;
      W_XFER: begin
        // a channel whose handshake already happened is parked until the FSM leaves XFER
        if (!aw_done) begin
          M_AWADDR        = s_awaddr[wgnt];
          M_AWVALID       = s_awvalid[wgnt];
          s_awready[wgnt] = M_AWREADY;
        end
        if (!w_done) begin
          M_WDATA        = s_wdata[wgnt];
          M_WSTRB        = s_wstrb[wgnt];
          M_WVALID       = s_wvalid[wgnt];
          s_wready[wgnt] = M_WREADY;
        end
        aw_hs = M_AWVALID & M_AWREADY;
        w_hs  = M_WVALID & M_WREADY;
        if ((aw_done | aw_hs) && (w_done | w_hs)) wstate_nxt = W_RESP;
      end
      W_RESP: begin
        s_bvalid[wgnt] = M_BVALID;
        s_bresp[wgnt]  = M_BRESP;
        M_BREADY       = s_bready[wgnt];
        b_hs           = M_BVALID & M_BREADY;
        if (b_hs) wstate_nxt = W_IDLE;
      end
      default: wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate  <= W_IDLE;
      wgnt    <= 1'b0;
      wlast   <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      wstate <= wstate_nxt;
      if (wstate == W_IDLE && w_any) wgnt <= w_pick;
      if (wstate == W_XFER) begin
        if (wstate_nxt == W_RESP) begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end else begin
          aw_done <= aw_done | aw_hs;
          w_done  <= w_done | w_hs;
        end
      end
      if (b_hs) wlast <= wgnt;
    end
  end

  // ---------------- read path ----------------
  rstate_t rstate, rstate_nxt;
  logic    rgnt, rlast, r_pick, r_any, r_hs;

  axil_rr_arb2 u_rarb (
    .req  (s_arvalid),
    .last (rlast),
    .gnt  (r_pick),
    .any  (r_any)
  );

  always_comb begin
    rstate_nxt = rstate;
    M_ARADDR   = '0;
    M_ARVALID  = 1'b0;
    M_RREADY   = 1'b0;
    s_arready  = '0;
    s_rvalid   = '0;
    s_rdata    = '0;
    s_rresp    = '0;
    r_hs       = 1'b0;
    case (rstate)
      R_IDLE: if (r_any) rstate_nxt = R_ADDR;
      R_ADDR: begin
        M_ARADDR        = s_araddr[rgnt];
        M_ARVALID       = s_arvalid[rgnt];
        s_arready[rgnt] = M_ARREADY;
        if (M_ARVALID && M_ARREADY) rstate_nxt = R_DATA;
      end
      R_DATA: begin
        s_rvalid[rgnt] = M_RVALID;
        s_rdata[rgnt]  = M_RDATA;
        s_rresp[rgnt]  = M_RRESP;
        M_RREADY       = s_rready[rgnt];
        r_hs           = M_RVALID & M_RREADY;
        if (r_hs) rstate_nxt = R_IDLE;
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rstate <= R_IDLE;
      rgnt   <= 1'b0;
      rlast  <= 1'b1;
    end else begin
      rstate <= rstate_nxt;
      if (rstate == R_IDLE && r_any) rgnt <= r_pick;
      if (r_hs) rlast <= rgnt;
    end
  end

endmodule

// File: tb/tb_axi4_lite_arbiter_2to1.sv
// Directed bench: two task-driven masters, a small behavioural register-file slave, grant log.
module tb_axi4_lite_arbiter_2to1;
  import axi4_lite_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       awvalid = '0, wvalid = '0, bready = '0, arvalid = '0, rready = '0;
  logic [1:0][31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [1:0][3:0]  wstrb = '0;
  logic [1:0]       awready, wready, bvalid, arready, rvalid;
  logic [1:0][1:0]  bresp, rresp;
  logic [1:0][31:0] rdata;

  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;

  axi4_lite_arbiter_2to1 #(.ADDRESS(32), .DATA_WIDTH(32)) dut (
    .ACLK(clk), .ARESET(rst),
    .S0_AWADDR(awaddr[0]), .S0_AWVALID(awvalid[0]), .S0_AWREADY(awready[0]),
    .S0_WDATA(wdata[0]), .S0_WSTRB(wstrb[0]), .S0_WVALID(wvalid[0]), .S0_WREADY(wready[0]),
    .S0_BRESP(bresp[0]), .S0_BVALID(bvalid[0]), .S0_BREADY(bready[0]),
    .S0_ARADDR(araddr[0]), .S0_ARVALID(arvalid[0]), .S0_ARREADY(arready[0]),
    .S0_RDATA(rdata[0]), .S0_RRESP(rresp[0]), .S0_RVALID(rvalid[0]), .S0_RREADY(rready[0]),
    .S1_AWADDR(awaddr[1]), .S1_AWVALID(awvalid[1]), .S1_AWREADY(awready[1]),
    .S1_WDATA(wdata[1]), .S1_WSTRB(wstrb[1]), .S1_WVALID(wvalid[1]), .S1_WREADY(wready[1]),
    .S1_BRESP(bresp[1]), .S1_BVALID(bvalid[1]), .S1_BREADY(bready[1]),
    .S1_ARADDR(araddr[1]), .S1_ARVALID(arvalid[1]), .S1_ARREADY(arready[1]),
    .S1_RDATA(rdata[1]), .S1_RRESP(rresp[1]), .S1_RVALID(rvalid[1]), .S1_RREADY(rready[1]),
    .M_AWADDR(m_awaddr), .M_AWVALID(m_awvalid), .M_AWREADY(m_awready),
    .M_WDATA(m_wdata), .M_WSTRB(m_wstrb), .M_WVALID(m_wvalid), .M_WREADY(m_wready),
    .M_BRESP(m_bresp), .M_BVALID(m_bvalid), .M_BREADY(m_bready),
    .M_ARADDR(m_araddr), .M_ARVALID(m_arvalid), .M_ARREADY(m_arready),
    .M_RDATA(m_rdata), .M_RRESP(m_rresp), .M_RVALID(m_rvalid), .M_RREADY(m_rready)
  );

  // behavioural slave: 16-word register file, misaligned access answers SLVERR with zero data
  logic [31:0] mem [16];
  logic        sl_aw_got, sl_w_got;
  logic [31:0] sl_awaddr, sl_wdata;
  logic [3:0]  sl_wstrb;

  initial for (int i = 0; i < 16; i++) mem[i] = '0;

  assign m_awready = !sl_aw_got && !m_bvalid;
  assign m_wready  = !sl_w_got && !m_bvalid;
  assign m_arready = !m_rvalid;

  always @(posedge clk) begin
    if (rst) begin
      sl_aw_got <= 1'b0; sl_w_got <= 1'b0;
      m_bvalid <= 1'b0; m_bresp <= '0;
      m_rvalid <= 1'b0; m_rdata <= '0; m_rresp <= '0;
    end else begin
      if (m_awvalid && m_awready) begin sl_aw_got <= 1'b1; sl_awaddr <= m_awaddr; end
      if (m_wvalid && m_wready) begin sl_w_got <= 1'b1; sl_wdata <= m_wdata; sl_wstrb <= m_wstrb; end
      if (sl_aw_got && sl_w_got && !m_bvalid) begin
        sl_aw_got <= 1'b0; sl_w_got <= 1'b0; m_bvalid <= 1'b1;
        if (sl_awaddr[1:0] != 2'b00) m_bresp <= RESP_SLVERR;
        else begin
          m_bresp <= RESP_OKAY;
          for (int b = 0; b < 4; b++)
            if (sl_wstrb[b]) mem[sl_awaddr[5:2]][b*8 +: 8] <= sl_wdata[b*8 +: 8];
        end
      end
      if (m_bvalid && m_bready) m_bvalid <= 1'b0;
      if (m_arvalid && m_arready) begin
        m_rvalid <= 1'b1;
        if (m_araddr[1:0] != 2'b00) begin m_rdata <= '0; m_rresp <= RESP_SLVERR; end
        else begin m_rdata <= mem[m_araddr[5:2]]; m_rresp <= RESP_OKAY; end
      end else if (m_rvalid && m_rready) m_rvalid <= 1'b0;
    end
  end

  // ---------------- checking ----------------
  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int aw_log[$];
  int b_cnt = 0, s1_rv_cnt = 0, both_aw_cnt = 0;
  always @(negedge clk) if (!rst) begin
    if (awvalid[0] && awready[0]) aw_log.push_back(0);
    if (awvalid[1] && awready[1]) aw_log.push_back(1);
    if (m_bvalid && m_bready) b_cnt++;
    if (rvalid[1]) s1_rv_cnt++;
    if (awready[0] && awready[1]) both_aw_cnt++;
  end

  // all tasks start and end at posedge+1
  task automatic do_write(input int p, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int w_lead, output logic [1:0] resp);
    int  cyc = 0;
    bit  aw_ok = 0, w_ok = 0, done = 0;
    resp = 2'b11;
    wvalid[p] = 1'b1; wdata[p] = d; wstrb[p] = s;
    if (w_lead == 0) begin awvalid[p] = 1'b1; awaddr[p] = a; end
    while (!(aw_ok && w_ok) && cyc < 200) begin
      @(negedge clk);
      if (awvalid[p] && awready[p]) aw_ok = 1;
      if (wvalid[p] && wready[p]) w_ok = 1;
      @(posedge clk); #1;
      if (aw_ok) awvalid[p] = 1'b0;
      if (w_ok) wvalid[p] = 1'b0;
      cyc++;
      if (!aw_ok && cyc >= w_lead) begin awvalid[p] = 1'b1; awaddr[p] = a; end
    end
    bready[p] = 1'b1;
    while (!done && cyc < 200) begin
      @(negedge clk);
      if (bvalid[p]) begin resp = bresp[p]; done = 1; end
      @(posedge clk); #1;
      cyc++;
    end
    bready[p] = 1'b0; awvalid[p] = 1'b0; wvalid[p] = 1'b0;
    chk($sformatf("wr%0d_done", p), {63'b0, done}, 64'd1);
  endtask

  task automatic do_read(input int p, input logic [31:0] a,
                         output logic [31:0] d, output logic [1:0] r);
    int cyc = 0;
    bit a_ok = 0, done = 0;
    d = 'x; r = 'x;
    arvalid[p] = 1'b1; araddr[p] = a; rready[p] = 1'b1;
    while (!done && cyc < 200) begin
      @(negedge clk);
      if (arvalid[p] && arready[p]) a_ok = 1;
      if (rvalid[p]) begin d = rdata[p]; r = rresp[p]; done = 1; end
      @(posedge clk); #1;
      if (a_ok) arvalid[p] = 1'b0;
      cyc++;
    end
    arvalid[p] = 1'b0; rready[p] = 1'b0;
    chk($sformatf("rd%0d_done", p), {63'b0, done}, 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [14:0] hs_bits();
    return {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
            awready, wready, bvalid, arready, rvalid};
  endfunction

  logic [1:0]  r0, r1, rr;
  logic [31:0] d0;

  initial begin
    do_reset();
    @(negedge clk);
    chk("reset_hs", hs_bits(), 0);
    chk("reset_payload", {m_awaddr, m_wdata | m_araddr}, 0);
    @(posedge clk); #1;

    // single write, then read back
    fork
      do_write(0, 32'h08, 32'hDEADBEEF, 4'hF, 0, r0);
      begin
        @(negedge clk); chk("t1_mawvalid_idle", m_awvalid, 0);
        @(negedge clk); chk("t1_mawvalid_grant", m_awvalid, 1);
        chk("t1_mawaddr", m_awaddr, 32'h08);
      end
    join
    chk("t1_bresp", r0, RESP_OKAY);
    do_read(0, 32'h08, d0, rr);
    chk("t1_rdata", d0, 32'hDEADBEEF);
    chk("t1_rresp", rr, RESP_OKAY);

    // simultaneous write tie right after reset
    do_reset();
    aw_log.delete();
    fork
      do_write(0, 32'h04, 32'h11, 4'hF, 0, r0);
      do_write(1, 32'h04, 32'h22, 4'hF, 0, r1);
    join
    chk("t2_log_size", aw_log.size(), 2);
    if (aw_log.size() == 2) begin
      chk("t2_first", aw_log[0], 0);
      chk("t2_second", aw_log[1], 1);
    end
    do_read(1, 32'h04, d0, rr);
    chk("t2_rdata", d0, 32'h22);

    // fairness: four back-to-back writes per master
    do_reset();
    aw_log.delete();
    both_aw_cnt = 0;
    fork
      for (int i = 0; i < 4; i++) do_write(0, 32'h20 + 4*i, 32'hA0 + i, 4'hF, 0, r0);
      for (int j = 0; j < 4; j++) do_write(1, 32'h30 + 4*j, 32'hB0 + j, 4'hF, 0, r1);
    join
    chk("t3_log_size", aw_log.size(), 8);
    if (aw_log.size() == 8)
      for (int k = 0; k < 8; k++) chk($sformatf("t3_grant%0d", k), aw_log[k], k % 2);
    chk("t3_both_ready", both_aw_cnt, 0);
    do_read(0, 32'h2C, d0, rr);
    chk("t3_rdata", d0, 32'hA3);

    // W three cycles ahead of AW on S1, concurrent S0 read of 0x00
    b_cnt = 0;
    fork
      do_write(1, 32'h0C, 32'h55AA55AA, 4'hF, 3, r1);
      do_read(0, 32'h00, d0, rr);
      begin
        @(negedge clk); chk("t4_mwvalid_idle", m_wvalid, 0);
        @(negedge clk); chk("t4_mwvalid_grant", m_wvalid, 1);
        chk("t4_mawvalid_grant", m_awvalid, 0);
      end
    join
    chk("t4_bcnt", b_cnt, 1);
    chk("t4_bresp", r1, RESP_OKAY);
    chk("t4_rd0", d0, 32'h0);
    do_read(1, 32'h0C, d0, rr);
    chk("t4_readback", d0, 32'h55AA55AA);

    // misaligned read answers SLVERR to S0 only
    s1_rv_cnt = 0;
    do_read(0, 32'h02, d0, rr);
    chk("t5_rresp", rr, RESP_SLVERR);
    chk("t5_rdata", d0, 32'h0);
    chk("t5_s1_rvalid", s1_rv_cnt, 0);

    // reset while the write path sits in XFER waiting for AW
    wvalid[0] = 1'b1; wdata[0] = 32'h99; wstrb[0] = 4'hF;
    @(posedge clk); #1;
    @(negedge clk); chk("t6_in_xfer", m_wvalid, 1);
    @(posedge clk); #1;
    rst = 1'b1; wvalid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_reset_hs", hs_bits(), 0);
    chk("t6_reset_payload", {m_awaddr, m_wdata | m_araddr}, 0);
    @(posedge clk); #1;
    aw_log.delete();
    fork
      do_write(1, 32'h14, 32'h0B, 4'hF, 0, r1);
      do_write(0, 32'h10, 32'h0A, 4'hF, 0, r0);
    join
    chk("t6_log_size", aw_log.size(), 2);
    if (aw_log.size() == 2) chk("t6_first", aw_log[0], 0);
    chk("t6_bresp0", r0, RESP_OKAY);
    chk("t6_bresp1", r1, RESP_OKAY);
    do_read(0, 32'h14, d0, rr);
    chk("t6_readback", d0, 32'h0B);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
